// File: rtl/led_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// led_ctrl_pkg : frame geometry shared by the LED shift register and PWM
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package led_ctrl_pkg;
    localparam int CHANNELS   = 4;
    localparam int PWM_BITS   = 4;
    localparam int FRAME_BITS = CHANNELS * PWM_BITS;
    localparam int PWM_MAX    = (1 << PWM_BITS) - 1;

    // Terminal value of the PWM counter; period is one tick shorter than 2^bits
    function automatic int pwm_top(input int bits);
        return (1 << bits) - 2;
    endfunction
endpackage

`default_nettype wire

// File: rtl/led_pwm_channel.sv
// ---------------------------------------------------------------------------
// led_pwm_channel : one registered PWM comparator (duty vs period counter)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module led_pwm_channel #(
    parameter int PWM_BITS   = 4,
    parameter bit LED_ACT_LO = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PWM_BITS-1:0] duty,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led
);
    logic r_led;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_led <= LED_ACT_LO;
        end else begin
            r_led <= (pwm_cnt < duty) ^ LED_ACT_LO;
        end
    end

    assign led = r_led;
endmodule

`default_nettype wire

// File: rtl/led_frame_pwm.sv
// ---------------------------------------------------------------------------
// led_frame_pwm : latches shifted LED frames, double-buffered multi-channel PWM
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module led_frame_pwm
    import led_ctrl_pkg::*;
#(
    parameter int CHANNELS   = led_ctrl_pkg::CHANNELS,
    parameter int PWM_BITS   = led_ctrl_pkg::PWM_BITS,
    parameter int PRESCALE   = 1,
    parameter bit LED_ACT_LO = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic [CHANNELS*PWM_BITS-1:0] shift_data,
    output logic [CHANNELS-1:0]          led,
    output logic                         frame_ok,
    output logic                         frame_err
);
    localparam int FRAME_W = CHANNELS * PWM_BITS;
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam int PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0]    CNT_SAT  = CNT_W'(FRAME_W + 1);
    localparam logic [PS_W-1:0]     PS_TOP   = PS_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] PWM_TOP  = PWM_BITS'(pwm_top(PWM_BITS));

    logic                r_en_d;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [FRAME_W-1:0]  r_shadow;
    logic [FRAME_W-1:0]  r_active;
    logic                r_pending;
    logic [PS_W-1:0]     r_presc;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic                r_frame_ok;
    logic                r_frame_err;

    logic w_rise;
    logic w_accept;
    logic w_reject;
    logic w_tick;
    logic w_wrap;

    // en is active-low, so its rising edge marks the end of a shift burst
    assign w_rise   = ~r_en_d & en;
    assign w_accept = w_rise && (r_bit_cnt == CNT_FULL);
    assign w_reject = w_rise && (r_bit_cnt != CNT_FULL) && (r_bit_cnt != '0);
    assign w_tick   = (r_presc == PS_TOP);
    assign w_wrap   = w_tick && (r_pwm_cnt == PWM_TOP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_en_d      <= 1'b1;
            r_bit_cnt   <= '0;
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_en_d      <= en;
            r_frame_ok  <= w_accept;
            r_frame_err <= w_reject;
            if (w_rise) begin
                r_bit_cnt <= '0;
            end else if (!en && (r_bit_cnt != CNT_SAT)) begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
        end
    end

    // A wrap coinciding with an accept copies the old shadow; the new one stays pending
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shadow  <= '0;
            r_active  <= '0;
            r_pending <= 1'b0;
        end else begin
            if (w_wrap && r_pending) begin
                r_active  <= r_shadow;
                r_pending <= 1'b0;
            end
            if (w_accept) begin
                r_shadow  <= shift_data;
                r_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc   <= '0;
            r_pwm_cnt <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PS_W'(1);
            if (w_tick) begin
                r_pwm_cnt <= w_wrap ? '0 : r_pwm_cnt + PWM_BITS'(1);
            end
        end
    end

    generate
        for (genvar k = 0; k < CHANNELS; k++) begin : g_channel
            led_pwm_channel #(
                .PWM_BITS   (PWM_BITS),
                .LED_ACT_LO (LED_ACT_LO)
            ) u_channel (
                .clk     (clk),
                .reset   (reset),
                .duty    (r_active[k*PWM_BITS +: PWM_BITS]),
                .pwm_cnt (r_pwm_cnt),
                .led     (led[k])
            );
        end
    endgenerate

    assign frame_ok  = r_frame_ok;
    assign frame_err = r_frame_err;
endmodule

`default_nettype wire

// File: tb/tb_led_frame_pwm.sv
// ---------------------------------------------------------------------------
// tb_led_frame_pwm : directed self-checking bench for led_frame_pwm
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_led_frame_pwm;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b1;
    logic [15:0] shift_data = '0;
    logic [3:0]  led, led_lo, led_slow;
    logic        ok, err, ok_lo, err_lo, ok_slow, err_slow;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int on_cnt[4];
    int inv_bad;
    int pulses;

    led_frame_pwm u_dut (
        .clk(clk), .reset(reset), .en(en), .shift_data(shift_data),
        .led(led), .frame_ok(ok), .frame_err(err)
    );

    led_frame_pwm #(.LED_ACT_LO(1'b1)) u_dut_lo (
        .clk(clk), .reset(reset), .en(en), .shift_data(shift_data),
        .led(led_lo), .frame_ok(ok_lo), .frame_err(err_lo)
    );

    // Period of 60 clocks leaves room for two complete frames between wraps
    led_frame_pwm #(.PRESCALE(4)) u_dut_slow (
        .clk(clk), .reset(reset), .en(en), .shift_data(shift_data),
        .led(led_slow), .frame_ok(ok_slow), .frame_err(err_slow)
    );

    always #5 clk = ~clk;

    // Edge count since reset release; after edge e the fast pwm_cnt is e % 15
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_frame(input logic [15:0] d, input int n);
        shift_data = 16'($urandom);
        en = 1'b0;
        repeat (n - 1) @(negedge clk);
        shift_data = d;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        shift_data = ~d;
    endtask

    task automatic count_window(input int n, input bit slow);
        logic [3:0] l;
        for (int k = 0; k < 4; k++) on_cnt[k] = 0;
        inv_bad = 0;
        pulses  = 0;
        for (int i = 0; i < n; i++) begin
            l = slow ? led_slow : led;
            for (int k = 0; k < 4; k++) on_cnt[k] += int'(l[k]);
            if (led_lo !== ~led) inv_bad++;
            if (ok || err) pulses++;
            @(negedge clk);
        end
    endtask

    task automatic wait_phase(input int m, input int r);
        for (int i = 0; i < 400 && (cyc % m) != r; i++) @(negedge clk);
        checks++;
        if ((cyc % m) != r) begin
            failures++;
            $display("FAIL wait_phase: cyc%%%0d got %0d required %0d", m, cyc % m, r);
        end
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b0;
        en = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (led !== 4'h0) begin failures++; $display("FAIL reset_led: got %h required 0", led); end
        checks++; if (led_lo !== 4'hF) begin failures++; $display("FAIL reset_led_lo: got %h required f", led_lo); end
        checks++; if (ok !== 1'b0) begin failures++; $display("FAIL reset_ok: got %b required 0", ok); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b required 0", err); end
        reset = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (led !== 4'h0 || ok !== 1'b0 || err !== 1'b0 || led_lo !== 4'hF) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL reset_idle: got %0d bad cycles required 0", bad); end
    endtask

    task automatic test_good_frame();
        int exp_c[4] = '{0, 1, 8, 15};
        send_frame(16'hF810, 16);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL good_ok: got %b required 1", ok); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL good_err: got %b required 0", err); end
        @(negedge clk);
        checks++; if (ok !== 1'b0) begin failures++; $display("FAIL good_ok_width: got %b required 0", ok); end
        repeat (16) @(negedge clk);
        count_window(15, 1'b0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (on_cnt[k] != exp_c[k]) begin
                failures++; $display("FAIL good_duty ch%0d: got %0d required %0d", k, on_cnt[k], exp_c[k]);
            end
        end
        checks++; if (inv_bad != 0) begin failures++; $display("FAIL act_lo_invert: got %0d bad required 0", inv_bad); end
    endtask

    task automatic test_bad_frames();
        int exp_c[4] = '{0, 1, 8, 15};
        int lens[2] = '{15, 17};
        for (int t = 0; t < 2; t++) begin
            send_frame(16'h0000, lens[t]);
            checks++; if (err !== 1'b1) begin failures++; $display("FAIL bad%0d_err: got %b required 1", lens[t], err); end
            checks++; if (ok !== 1'b0) begin failures++; $display("FAIL bad%0d_ok: got %b required 0", lens[t], ok); end
            @(negedge clk);
            checks++; if (err !== 1'b0) begin failures++; $display("FAIL bad%0d_err_width: got %b required 0", lens[t], err); end
            repeat (16) @(negedge clk);
            count_window(15, 1'b0);
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (on_cnt[k] != exp_c[k]) begin
                    failures++; $display("FAIL bad%0d_duty ch%0d: got %0d required %0d", lens[t], k, on_cnt[k], exp_c[k]);
                end
            end
        end
    endtask

    task automatic test_wrap_accept();
        int old_c[4] = '{0, 1, 8, 15};
        int new_c[4] = '{15, 6, 12, 3};
        wait_phase(15, 13);
        send_frame(16'h3C6F, 16);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL wrap_ok: got %b required 1", ok); end
        @(negedge clk);
        count_window(15, 1'b0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (on_cnt[k] != old_c[k]) begin
                failures++; $display("FAIL wrap_old ch%0d: got %0d required %0d", k, on_cnt[k], old_c[k]);
            end
        end
        count_window(15, 1'b0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (on_cnt[k] != new_c[k]) begin
                failures++; $display("FAIL wrap_new ch%0d: got %0d required %0d", k, on_cnt[k], new_c[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        wait_phase(60, 1);
        send_frame(16'h1111, 16);
        checks++; if (ok_slow !== 1'b1) begin failures++; $display("FAIL b2b_first_ok: got %b required 1", ok_slow); end
        send_frame(16'h2222, 16);
        checks++; if (ok_slow !== 1'b1) begin failures++; $display("FAIL b2b_second_ok: got %b required 1", ok_slow); end
        wait_phase(60, 1);
        count_window(60, 1'b1);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (on_cnt[k] != 8) begin
                failures++; $display("FAIL b2b_duty ch%0d: got %0d required 8", k, on_cnt[k]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        shift_data = 16'hA5A5;
        en = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (led !== 4'h0) begin failures++; $display("FAIL mid_reset_led: got %h required 0", led); end
        checks++; if (led_lo !== 4'hF) begin failures++; $display("FAIL mid_reset_led_lo: got %h required f", led_lo); end
        repeat (3) @(negedge clk);
        en = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        count_window(20, 1'b0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (on_cnt[k] != 0) begin
                failures++; $display("FAIL mid_reset_cleared ch%0d: got %0d required 0", k, on_cnt[k]);
            end
        end
        checks++; if (pulses != 0) begin failures++; $display("FAIL mid_reset_pulse: got %0d required 0", pulses); end
        checks++; if (inv_bad != 0) begin failures++; $display("FAIL mid_reset_act_lo: got %0d bad required 0", inv_bad); end
        send_frame(16'hF810, 16);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL mid_reset_ok: got %b required 1", ok); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL mid_reset_err: got %b required 0", err); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_good_frame();
        test_bad_frames();
        test_wrap_accept();
        test_back_to_back();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
